// File: rtl/n64_joybus_responder_tx.sv
`default_nettype none
// ============================================================================
//  Module   : n64_joybus_responder_tx
//  Purpose  : Joybus responder transmitter for a fake N64 controller. Latches
//             a decoded command and its operands on start, then serialises
//             the INFO / STATUS / READ(+CRC) / WRITE response onto the line.
//  Revision : 1.0 - initial release
// ============================================================================
module n64_joybus_responder_tx #(
  parameter int          LEVEL_WIDTH = 2,
  parameter logic [23:0] CTRL_ID     = 24'h050000,
  parameter int          READ_BYTES  = 32,
  parameter int          AW          = $clog2(READ_BYTES)
) (
  input  logic          sample_clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    cmd,
  input  logic [31:0]   status,
  input  logic [7:0]    data_crc,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          data_tx,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int CYC_W  = $clog2(4 * LEVEL_WIDTH);
  localparam int BYTE_W = $clog2(READ_BYTES + 1);

  // Quarter-bit boundaries within one bit time, in sample_clk cycles
  localparam logic [CYC_W-1:0]  c_lvl1      = CYC_W'(LEVEL_WIDTH);
  localparam logic [CYC_W-1:0]  c_lvl2      = CYC_W'(2 * LEVEL_WIDTH);
  localparam logic [CYC_W-1:0]  c_lvl3      = CYC_W'(3 * LEVEL_WIDTH);
  localparam logic [CYC_W-1:0]  c_bit_last  = CYC_W'(4 * LEVEL_WIDTH - 1);
  localparam logic [BYTE_W-1:0] c_crc_byte  = BYTE_W'(READ_BYTES);
  localparam logic [BYTE_W-1:0] c_last_data = BYTE_W'(READ_BYTES - 1);
  localparam logic [7:0]        c_poly      = 8'h85;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_is_read;
  logic [31:0]         r_word;       // remaining non-READ response bytes, left aligned
  logic [7:0]          r_shreg;      // current byte, MSB is the bit on the line
  logic [7:0]          r_crc;
  logic [CYC_W-1:0]    r_cyc;        // cycle within the current bit
  logic [2:0]          r_bit;
  logic [BYTE_W-1:0]   r_byte;
  logic [BYTE_W-1:0]   r_last_byte;

  logic                w_cmd_valid;
  logic                w_bit_end;
  logic                w_byte_end;
  logic                w_frame_end;
  logic                w_fb;
  logic                w_next_bitval;
  logic [7:0]          w_crc_next;
  logic [7:0]          w_next_byte;
  logic [CYC_W-1:0]    w_next_cyc;

  // Line level for a data bit: low first quarter, bit value for two, high last
  function automatic logic f_bit_level(input logic [CYC_W-1:0] cyc, input logic b);
    if (cyc < c_lvl1)      return 1'b0;
    else if (cyc < c_lvl3) return b;
    else                   return 1'b1;
  endfunction

  // Bit/byte boundary decode, CRC step and the next byte / next bit to send
  always_comb begin
    w_cmd_valid = (cmd == 8'h00) || (cmd == 8'hFF) || (cmd == 8'h01) ||
                  (cmd == 8'h02) || (cmd == 8'h03);
    w_bit_end   = (r_cyc == c_bit_last);
    w_byte_end  = w_bit_end && (r_bit == 3'd7);
    w_frame_end = w_byte_end && (r_byte == r_last_byte);
    w_next_cyc  = w_bit_end ? '0 : r_cyc + 1'b1;
    // CRC including the bit currently on the line (MSB-first, poly 0x85)
    w_fb        = r_crc[7] ^ r_shreg[7];
    w_crc_next  = {r_crc[6:0], 1'b0} ^ (w_fb ? c_poly : 8'h00);
    if (!r_is_read)
      w_next_byte = r_word[31:24];
    else if (r_byte == c_last_data)
      w_next_byte = w_crc_next;    // final data bit folded in this same cycle
    else
      w_next_byte = rd_data;
    if (w_byte_end)
      w_next_bitval = w_next_byte[7];
    else if (w_bit_end)
      w_next_bitval = r_shreg[6];
    else
      w_next_bitval = r_shreg[7];
  end

  // Response sequencer: command latch, timing counters, line level and CRC
  always_ff @(posedge sample_clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_is_read   <= 1'b0;
      r_word      <= '0;
      r_shreg     <= '0;
      r_crc       <= 8'h00;
      r_cyc       <= '0;
      r_bit       <= '0;
      r_byte      <= '0;
      r_last_byte <= '0;
      rd_addr     <= '0;
      data_tx     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          rd_addr <= '0;
          data_tx <= 1'b1;
          busy    <= start;
          if (start) begin
            r_crc     <= 8'h00;
            r_is_read <= (cmd == 8'h02);
            case (cmd)
              8'h00, 8'hFF: begin
                r_word      <= {CTRL_ID, 8'h00};
                r_last_byte <= BYTE_W'(2);
              end
              8'h01: begin
                r_word      <= status;
                r_last_byte <= BYTE_W'(3);
              end
              8'h02: begin
                r_word      <= '0;
                r_last_byte <= c_crc_byte;
              end
              8'h03: begin
                r_word      <= {data_crc, 24'h000000};
                r_last_byte <= '0;
              end
              default: ;
            endcase
            if (w_cmd_valid) begin
              r_state <= S_LOAD;
            end else begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          r_shreg <= r_is_read ? rd_data : r_word[31:24];
          r_word  <= {r_word[23:0], 8'h00};
          r_cyc   <= '0;
          r_bit   <= '0;
          r_byte  <= '0;
          data_tx <= 1'b0;
          if (r_is_read)
            rd_addr <= AW'(1);
          r_state <= S_SEND;
        end

        S_SEND: begin
          r_cyc   <= w_next_cyc;
          data_tx <= f_bit_level(w_next_cyc, w_next_bitval);
          if (w_bit_end) begin
            r_bit   <= r_bit + 3'd1;
            r_shreg <= {r_shreg[6:0], 1'b0};
            if (r_is_read && (r_byte != c_crc_byte))
              r_crc <= w_crc_next;
          end
          if (w_frame_end) begin
            r_state <= S_STOP;
            data_tx <= 1'b0;
          end else if (w_byte_end) begin
            r_byte  <= r_byte + 1'b1;
            r_shreg <= w_next_byte;
            r_word  <= {r_word[23:0], 8'h00};
            // Address runs one byte ahead; held once the last data byte starts
            if (r_is_read && (r_byte != c_last_data))
              rd_addr <= rd_addr + 1'b1;
          end
        end

        S_STOP: begin
          r_cyc   <= w_next_cyc;
          data_tx <= (w_next_cyc >= c_lvl2);
          if (w_bit_end) begin
            r_state <= S_IDLE;
            data_tx <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/n64_joybus_responder_tx.md
# n64_joybus_responder_tx

Parametrised Joybus responder transmitter for the fake N64 controller. On a `start` strobe it latches the received command and its operands, then serialises the matching response onto the single-wire line: INFO, STATUS, READ (data block plus an internally computed data CRC) or WRITE (the data CRC supplied by the receive side). It sits between the command decoder/receiver and the open-drain line driver, and hands the line back via `done`.

## Interface
- `LEVEL_WIDTH`, 2: `sample_clk` cycles per quarter-bit level; bit time = 4*LEVEL_WIDTH cycles.
- `CTRL_ID`, 24'h050000: 3-byte INFO/RESET response, MSB first.
- `READ_BYTES`, 32: data bytes in a READ response; power of two, ≥2.
- `AW`, $clog2(READ_BYTES): width of `rd_addr`; derived, not overridden.

- `sample_clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; accepted only in IDLE.
- `cmd` in 8: command byte, sampled on accepted `start`.
- `status` in 32: STATUS response word, sampled on accepted `start`.
- `data_crc` in 8: WRITE response byte, sampled on accepted `start`.
- `rd_addr` out AW: READ buffer byte address.
- `rd_data` in 8: byte at `rd_addr`, valid the cycle after `rd_addr` changes.
- `data_tx` out 1: line level, 1 = released/high.
- `busy` out 1: high from `start` acceptance until `done`.
- `done` out 1: one-cycle pulse at end of response or on rejection.
- `err` out 1: one-cycle pulse with `done` for unsupported `cmd`.

## Operation
- Reset values: `data_tx`=1, `busy`=0, `done`=0, `err`=0, `rd_addr`=0, state IDLE, CRC=0x00.
- Command map (N = response bytes): 0x00/0xFF → CTRL_ID, N=3; 0x01 → `status`, N=4; 0x02 → READ_BYTES bytes from `rd_addr` 0..READ_BYTES-1 then CRC, N=READ_BYTES+1; 0x03 → `data_crc`, N=1; anything else → no transmission, `done`+`err` pulse.
- States: IDLE → LOAD (accepted `start`, valid cmd) → SEND (8*N bits) → STOP (one stop bit) → IDLE with `done`. Invalid cmd: IDLE → IDLE with `done`/`err`; `busy` high for that one cycle.
- Bytes sent MSB first; bit encoding in levels: 0 = L,L,L,H; 1 = L,H,H,H; stop = L,L,H,H. Each level lasts LEVEL_WIDTH cycles.
- Byte shift register reloaded at each byte boundary; bit counter 0..7, byte counter 0..N-1.
- READ: `rd_addr`=0 in IDLE; advanced to k+1 on first cycle of byte k; `rd_data` sampled on last cycle of byte k. Final byte is the CRC register.
- Data CRC: poly 0x85 (x^8+x^7+x^2+1), init 0x00, MSB-first, no reflection, no final XOR, over the READ_BYTES data bytes; updated bitwise as each data bit is shifted out; cleared on `start` acceptance.
- `start` while `busy` ignored; operand input changes after acceptance ignored.

## Timing
- `start` sampled high at edge T: `busy`=1 from T+1; LOAD at T+1; first falling edge of `data_tx` at T+2.
- Frame length = (8*N+1)*4*LEVEL_WIDTH cycles; `data_tx` returns to 1 in the last 2*LEVEL_WIDTH cycles (stop bit), stays 1 afterwards.
- `done` high exactly one cycle, the cycle after the final stop-bit cycle; `busy` falls on that same cycle; new `start` accepted on it.
- Invalid cmd: `done`/`err` high at T+1, `data_tx` never leaves 1.
- `reset` mid-frame: next edge forces all reset values; no `done` pulse; truncated frame not resumed.
- Level/bit/byte counters never wrap within a frame; the byte counter is sized for READ_BYTES+1.

## Test plan
- LEVEL_WIDTH=2, `cmd`=0x00 → 200-cycle frame, bit pattern 0x05,0x00,0x00 + stop, `done` at T+202, `err`=0.
- `cmd`=0x01, `status`=0x80FF7F01, `status` toggled mid-frame → 264-cycle frame carrying 0x80FF7F01 unaltered.
- `cmd`=0x02, buffer all 0x00 → 33 bytes all 0x00 (CRC 0x00); buffer `rd_data`=address → bytes 0x00..0x1F then CRC matching bench reference model; `rd_addr` sequencing checked per byte.
- `cmd`=0x03, `data_crc`=0xA5 → 72-cycle frame, byte 0xA5 + stop; second `start` during frame ignored.
- `cmd`=0x7E → `done`+`err` pulse at T+1, `data_tx` constant 1, `busy` high one cycle.
- `reset` asserted in byte 10 of READ → `data_tx`=1, `busy`=0 next cycle, no `done`; following `cmd`=0x00 frame correct.
